// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: fetch-sequencer state encodings and the core address-width default.
package fetch_ctrl_pkg;
    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_WAIT = 2'd2,
        FS_HALT = 2'd3
    } fetch_state_t;
    localparam int XLEN_DEFAULT = 32;
endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: free-running stall-cycle and redirect-flush counters (FETCH_PERF_CNT_EN builds only).
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_flush,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            stall_cycles <= stall_cycles + 32'(stall);
            flush_count  <= flush_count + 32'(redirect_flush);
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer arbitrating boot hold, redirects, halt, load-use stalls and imem waits.
// Optional FETCH_PERF_CNT_EN adds stall_cycles / flush_count performance counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int BOOT_HOLD = 4,
    parameter int XLEN      = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            load_use_hazard,
    input  logic            imem_ready,
    input  logic            halt_req,
    output logic            PC_write,
    output logic            PCSrc,
    output logic [XLEN-1:0] PC_Branch,
    output logic            IF_ID_write,
    output logic            IF_ID_flush,
    output logic            ID_EX_flush,
    output logic [1:0]      fetch_state,
    output logic            halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);
    localparam int CW = BOOT_HOLD > 1 ? $clog2(BOOT_HOLD) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(BOOT_HOLD > 0 ? BOOT_HOLD - 1 : 0);
    localparam fetch_state_t ST_INIT = BOOT_HOLD == 0 ? FS_RUN : FS_BOOT;

    fetch_state_t    state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            pend_valid, pend_valid_nxt;
    logic [XLEN-1:0] pend_target, pend_target_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_INIT;
            cnt         <= CNT_INIT;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
        PC_write        = 1'b0;
        PCSrc           = 1'b0;
        IF_ID_write     = 1'b0;
        IF_ID_flush     = 1'b0;
        ID_EX_flush     = 1'b0;
        case (state)
            FS_BOOT: begin
                IF_ID_flush = 1'b1;
                cnt_nxt     = cnt - CW'(1);
                state_nxt   = cnt == '0 ? FS_RUN : FS_BOOT;
            end
            FS_RUN: begin
                pend_valid_nxt = 1'b0;
                // A live branch squashes everything younger, so it outranks a deferred redirect.
                if (branch_taken || pend_valid) begin
                    PCSrc       = 1'b1;
                    PC_write    = 1'b1;
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = branch_taken;
                end else if (halt_req) begin
                    state_nxt = FS_HALT;
                end else if (load_use_hazard) begin
                    ID_EX_flush = 1'b1;
                end else if (!imem_ready) begin
                    IF_ID_flush = 1'b1;
                    state_nxt   = FS_WAIT;
                end else begin
                    PC_write    = 1'b1;
                    IF_ID_write = 1'b1;
                end
            end
            FS_WAIT: begin
                if (branch_taken) begin
                    PCSrc       = 1'b1;
                    PC_write    = 1'b1;
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                    state_nxt   = FS_RUN;
                end else if (imem_ready) begin
                    PC_write    = 1'b1;
                    IF_ID_write = 1'b1;
                    state_nxt   = FS_RUN;
                end else begin
                    IF_ID_flush = 1'b1;
                end
            end
            default: begin
                if (branch_taken) begin
                    pend_valid_nxt  = 1'b1;
                    pend_target_nxt = branch_target;
                    ID_EX_flush     = 1'b1;
                end
                state_nxt = halt_req ? FS_HALT : FS_RUN;
            end
        endcase
    end

    assign PC_Branch   = !PCSrc ? '0 : branch_taken ? branch_target : pend_target;
    assign fetch_state = state;
    assign halted      = state == FS_HALT;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt u_perf (
        .clk            (clk),
        .reset          (reset),
        .stall          ((state == FS_RUN || state == FS_WAIT) && !PC_write),
        .redirect_flush (PCSrc),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table, hand-written reset/redirect sequences and random run against a queue-based model.
module tb_fetch_ctrl;
    localparam int BH = 4;

    typedef struct packed {
        logic        pw;
        logic        ps;
        logic [31:0] pb;
        logic        iw;
        logic        ifl;
        logic        efl;
        logic [1:0]  st;
        logic        hl;
    } exp_t;

    typedef struct packed {
        logic        r;
        logic        bt;
        logic [31:0] tgt;
        logic        lu;
        logic        rdy;
        logic        hr;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        load_use_hazard = 1'b0;
    logic        imem_ready = 1'b1;
    logic        halt_req = 1'b0;
    logic        PC_write, PCSrc, IF_ID_write, IF_ID_flush, ID_EX_flush, halted;
    logic [31:0] PC_Branch;
    logic [1:0]  fetch_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    int          m_mode;
    int          m_boot_left;
    logic [31:0] m_pend[$];

    fetch_ctrl #(.BOOT_HOLD(BH), .XLEN(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .load_use_hazard (load_use_hazard),
        .imem_ready      (imem_ready),
        .halt_req        (halt_req),
        .PC_write        (PC_write),
        .PCSrc           (PCSrc),
        .PC_Branch       (PC_Branch),
        .IF_ID_write     (IF_ID_write),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_flush     (ID_EX_flush),
        .fetch_state     (fetch_state),
        .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic r, input logic bt, input logic [31:0] tgt,
                                 input logic lu, input logic rdy, input logic hr,
                                 input logic pw, input logic ps, input logic [31:0] pb,
                                 input logic iw, input logic ifl, input logic efl,
                                 input logic [1:0] st, input logic hl);
        vec_t v;
        v.r = r; v.bt = bt; v.tgt = tgt; v.lu = lu; v.rdy = rdy; v.hr = hr;
        v.e.pw = pw; v.e.ps = ps; v.e.pb = pb; v.e.iw = iw;
        v.e.ifl = ifl; v.e.efl = efl; v.e.st = st; v.e.hl = hl;
        return v;
    endfunction

    task automatic add(input logic r, input logic bt, input logic [31:0] tgt,
                       input logic lu, input logic rdy, input logic hr,
                       input logic pw, input logic ps, input logic [31:0] pb,
                       input logic iw, input logic ifl, input logic efl,
                       input logic [1:0] st, input logic hl);
        tbl.push_back(mkv(r, bt, tgt, lu, rdy, hr, pw, ps, pb, iw, ifl, efl, st, hl));
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e);
        chk({tag, ".PC_write"}, 32'(PC_write), 32'(e.pw));
        chk({tag, ".PCSrc"}, 32'(PCSrc), 32'(e.ps));
        chk({tag, ".PC_Branch"}, PC_Branch, e.pb);
        chk({tag, ".IF_ID_write"}, 32'(IF_ID_write), 32'(e.iw));
        chk({tag, ".IF_ID_flush"}, 32'(IF_ID_flush), 32'(e.ifl));
        chk({tag, ".ID_EX_flush"}, 32'(ID_EX_flush), 32'(e.efl));
        chk({tag, ".fetch_state"}, 32'(fetch_state), 32'(e.st));
        chk({tag, ".halted"}, 32'(halted), 32'(e.hl));
    endtask

    // Reference model: mode number, remaining boot cycles, and a queue of redirects seen while halted.
    function automatic void model_reset();
        m_mode = BH == 0 ? 1 : 0;
        m_boot_left = BH;
        m_pend.delete();
    endfunction

    function automatic exp_t model_out();
        exp_t e = '0;
        if (!reset) begin
            e.ifl = 1'b1;
            return e;
        end
        e.st = 2'(m_mode);
        if (m_mode == 0) e.ifl = 1'b1;
        else if (m_mode == 3) begin
            e.hl = 1'b1;
            e.efl = branch_taken;
        end else if (branch_taken || (m_mode == 1 && m_pend.size() > 0)) begin
            e.ps = 1'b1;
            e.pw = 1'b1;
            e.ifl = 1'b1;
            e.efl = branch_taken;
            e.pb = branch_taken ? branch_target : m_pend[$];
        end else if (m_mode == 2) begin
            e.pw = imem_ready;
            e.iw = imem_ready;
            e.ifl = !imem_ready;
        end else if (halt_req) begin
        end else if (load_use_hazard) e.efl = 1'b1;
        else if (!imem_ready) e.ifl = 1'b1;
        else begin
            e.pw = 1'b1;
            e.iw = 1'b1;
        end
        return e;
    endfunction

    function automatic void model_step();
        bit redirect;
        if (!reset) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                m_boot_left--;
                if (m_boot_left == 0) m_mode = 1;
            end
            1: begin
                redirect = branch_taken || m_pend.size() > 0;
                m_pend.delete();
                if (!redirect && halt_req) m_mode = 3;
                else if (!redirect && !load_use_hazard && !imem_ready) m_mode = 2;
            end
            2: if (branch_taken || imem_ready) m_mode = 1;
            default: begin
                if (branch_taken) m_pend.push_back(branch_target);
                if (!halt_req) m_mode = 1;
            end
        endcase
    endfunction

    task automatic drive(input logic r, input logic bt, input logic [31:0] tgt,
                         input logic lu, input logic rdy, input logic hr);
        reset = r; branch_taken = bt; branch_target = tgt;
        load_use_hazard = lu; imem_ready = rdy; halt_req = hr;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        drive(v.r, v.bt, v.tgt, v.lu, v.rdy, v.hr);
        cmp_all(tag, v.e);
        advance();
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // r bt tgt lu rdy hr | pw ps pb iw ifl efl st hl
        add(0, 1, 32'h55, 1, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < BH; i++)
            add(1, 1, 32'h77, 1, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 1, 0);
        add(1, 1, 32'h40, 1, 1, 0,  1, 1, 32'h40, 0, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 2, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 2, 0);
        add(1, 0, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 2, 0);
        add(1, 0, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 1, 32'h100, 0, 1, 1,  0, 0, 0, 0, 0, 1, 3, 1);
        add(1, 1, 32'h200, 0, 1, 1,  0, 0, 0, 0, 0, 1, 3, 1);
        add(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 3, 1);
        add(1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 3, 1);
        add(1, 0, 0, 0, 1, 0,  1, 1, 32'h200, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 1, 0, 1,  0, 0, 0, 0, 1, 0, 2, 0);
        add(1, 1, 32'hdeadbeec, 0, 0, 1,  1, 1, 32'hdeadbeec, 0, 1, 1, 2, 0);
        add(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 3, 1);
        add(1, 0, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Reset dropped while waiting on imem: BOOT outputs appear before the next edge.
        run_vec("h_wait",  mkv(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 0));
        run_vec("h_rstw",  mkv(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < BH; i++)
            run_vec($sformatf("h_boot%0d", i), mkv(1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0));
        run_vec("h_run",   mkv(1, 0, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 1, 0));
        // A redirect latched in HALT must be discarded by reset.
        run_vec("h_halt",  mkv(1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1, 0));
        run_vec("h_latch", mkv(1, 1, 32'h300, 0, 1, 1,  0, 0, 0, 0, 0, 1, 3, 1));
        run_vec("h_rsth",  mkv(0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < BH; i++)
            run_vec($sformatf("h_boot2_%0d", i), mkv(1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0));
        run_vec("h_nored", mkv(1, 0, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 1, 0));
        run_vec("h_nored2", mkv(1, 0, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 1, 0));

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 5) == 0, $urandom,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                  halt_req ? $urandom_range(0, 3) != 0 : $urandom_range(0, 9) == 0);
            cmp_all($sformatf("rnd%0d", i), model_out());
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
